// File: rtl/fetch_prefetch.sv
// Fetch stage: in-order requests to a variable-latency imem, with a credit-limited prefetch
// queue feeding decode over a valid/ready handshake. Redirects flush the queue and squash replies.
module fetch_prefetch #(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    DEPTH           = 4,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC        = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR       = 'h13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  PCSrcE,
  input  logic                  JALRinstrE,
  input  logic [DATA_WIDTH-1:0] ALUResultE,
  input  logic [DATA_WIDTH-1:0] PCtargetE,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  validF,
  output logic [DATA_WIDTH-1:0] instrF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PCPlus4F
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(DEPTH + MAX_OUTSTANDING + 1);

  logic [DATA_WIDTH-1:0] pc_p0;
  logic [DATA_WIDTH-1:0] tag_mem_p0 [MAX_OUTSTANDING];
  logic [TW-1:0]         tag_wp, tag_rp;
  logic [CW-1:0]         outstanding, drop, count;
  logic [DATA_WIDTH-1:0] q_pc_p1    [DEPTH];
  logic [DATA_WIDTH-1:0] q_instr_p1 [DEPTH];
  logic [AW-1:0]         q_wp, q_rp;

  logic                  redirect, issue, resp, push, pop;
  logic [DATA_WIDTH-1:0] target;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
  endfunction

  assign redirect  = JALRinstrE | PCSrcE;
  assign target    = JALRinstrE ? (ALUResultE & {{(DATA_WIDTH-1){1'b1}}, 1'b0}) : PCtargetE;
  // Credits cover queued entries plus in-flight requests, so a response always has a slot.
  assign imem_req  = !reset && !redirect && (outstanding < CW'(MAX_OUTSTANDING))
                     && ((count + outstanding) < CW'(DEPTH));
  assign imem_addr = pc_p0;
  assign issue     = imem_req && imem_ready;
  // A response with nothing outstanding is a protocol violation and is ignored.
  assign resp      = imem_rvalid && (outstanding != '0);
  assign push      = resp && (drop == '0) && !redirect;
  assign pop       = validF && enable;

  // Stage p0 -> p1: request issue, tag tracking, response capture into the queue
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0       <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      tag_wp      <= '0;
      tag_rp      <= '0;
      q_wp        <= '0;
      q_rp        <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(resp);
      if (issue) tag_wp <= tag_inc(tag_wp);
      if (resp)  tag_rp <= tag_inc(tag_rp);
      if (redirect) begin
        pc_p0 <= target;
        count <= '0;
        q_wp  <= '0;
        q_rp  <= '0;
        drop  <= outstanding - CW'(resp);
      end else begin
        if (issue) pc_p0 <= pc_p0 + DATA_WIDTH'(4);
        if (resp && (drop != '0)) drop <= drop - CW'(1);
        if (push) q_wp <= q_wp + AW'(1);
        if (pop)  q_rp <= q_rp + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) tag_mem_p0[tag_wp] <= pc_p0;
    if (push) begin
      q_pc_p1[q_wp]    <= tag_mem_p0[tag_rp];
      q_instr_p1[q_wp] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(imem_rvalid && (outstanding == '0)));
  end

  // Stage p1 -> decode: head of the registered queue
  assign validF   = (count != '0);
  assign instrF   = validF ? q_instr_p1[q_rp] : NOP_INSTR;
  assign PCF      = validF ? q_pc_p1[q_rp] : RESET_PC;
  assign PCPlus4F = PCF + DATA_WIDTH'(4);

endmodule
